// File: rtl/intersection_phase_scheduler.sv
// Four-way intersection sequencer: GREEN/YELLOW/ALLRED/PED phases counted in ticks,
// with round-robin road selection by occupancy, pedestrian insertion and emergency preemption.
module intersection_phase_scheduler #(
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned PED_TIME    = 10,
    parameter int unsigned MIN_GREEN   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] tg_n,
    input  logic [7:0] tg_e,
    input  logic [7:0] tg_s,
    input  logic [7:0] tg_w,
    input  logic [3:0] occ,
    input  logic       ped_req,
    input  logic       em_req,
    input  logic [1:0] em_road,
    output logic [1:0] phase,
    output logic [1:0] green_road,
    output logic [2:0] n_light,
    output logic [2:0] e_light,
    output logic [2:0] s_light,
    output logic [2:0] w_light,
    output logic       walk,
    output logic [7:0] count,
    output logic       em_active,
    output logic       ped_pending,
    output logic       road_strobe
);

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_PED    = 2'd3
    } phase_t;

    localparam logic [7:0] C_YEL  = 8'(YELLOW_TIME);
    localparam logic [7:0] C_AR   = 8'(ALLRED_TIME);
    localparam logic [7:0] C_PED  = 8'(PED_TIME);
    localparam logic [7:0] C_MING = 8'(MIN_GREEN);

    phase_t          r_phase, w_phase_nx;
    logic [1:0]      r_road, w_road_nx, w_next_road;
    logic [7:0]      r_count, w_count_nx;
    logic            r_em, w_em_nx;
    logic            r_ped, w_ped_nx;
    logic            r_strobe, w_strobe_nx;
    logic            r_walk;
    logic [3:0][2:0] r_lights, w_lights_nx;
    logic [3:0][7:0] w_tg;
    logic            w_found;

    assign w_tg = {tg_w, tg_s, tg_e, tg_n};

    function automatic logic [7:0] clamp_green(input logic [7:0] tg);
        return (tg < C_MING) ? C_MING : tg;
    endfunction

    // First occupied road after the current one; the current road itself is tried last.
    always_comb begin
        w_next_road = r_road + 2'd1;
        w_found     = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            if (!w_found && occ[2'(r_road + 2'(k))]) begin
                w_next_road = 2'(r_road + 2'(k));
                w_found     = 1'b1;
            end
        end
    end

    always_comb begin
        w_phase_nx  = r_phase;
        w_road_nx   = r_road;
        w_count_nx  = r_count;
        w_em_nx     = r_em;
        w_ped_nx    = r_ped | (ped_req && (r_phase != PH_PED));
        w_strobe_nx = 1'b0;
        unique case (r_phase)
            PH_GREEN: begin
                if (em_req && (em_road != r_road)) begin
                    w_phase_nx = PH_YELLOW;
                    w_count_nx = C_YEL;
                    w_em_nx    = 1'b0;
                end else if (em_req) begin
                    w_em_nx = 1'b1;
                end else if (r_em) begin
                    w_phase_nx = PH_YELLOW;
                    w_count_nx = C_YEL;
                    w_em_nx    = 1'b0;
                end else if (tick) begin
                    if (r_count > 8'd1) begin
                        w_count_nx = r_count - 8'd1;
                    end else begin
                        w_phase_nx = PH_YELLOW;
                        w_count_nx = C_YEL;
                    end
                end
            end
            PH_YELLOW: begin
                if (tick) begin
                    if (r_count > 8'd1) begin
                        w_count_nx = r_count - 8'd1;
                    end else begin
                        w_phase_nx = PH_ALLRED;
                        w_count_nx = C_AR;
                    end
                end
            end
            PH_PED: begin
                if (em_req) begin
                    // Interrupted walk is re-requested so it is served after the emergency.
                    w_phase_nx = PH_ALLRED;
                    w_count_nx = C_AR;
                    w_ped_nx   = 1'b1;
                end else if (tick) begin
                    if (r_count > 8'd1) begin
                        w_count_nx = r_count - 8'd1;
                    end else begin
                        w_phase_nx = PH_ALLRED;
                        w_count_nx = C_AR;
                    end
                end
            end
            PH_ALLRED: begin
                if (tick) begin
                    if (r_count > 8'd1) begin
                        w_count_nx = r_count - 8'd1;
                    end else if (em_req) begin
                        w_phase_nx  = PH_GREEN;
                        w_road_nx   = em_road;
                        w_count_nx  = clamp_green(w_tg[em_road]);
                        w_em_nx     = 1'b1;
                        w_strobe_nx = 1'b1;
                    end else if (r_ped) begin
                        w_phase_nx = PH_PED;
                        w_count_nx = C_PED;
                        w_ped_nx   = 1'b0;
                    end else begin
                        w_phase_nx  = PH_GREEN;
                        w_road_nx   = w_next_road;
                        w_count_nx  = clamp_green(w_tg[w_next_road]);
                        w_em_nx     = 1'b0;
                        w_strobe_nx = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        for (int unsigned r = 0; r < 4; r++) begin
            w_lights_nx[r] = 3'b001;
            if (w_road_nx == 2'(r)) begin
                if (w_phase_nx == PH_GREEN) begin
                    w_lights_nx[r] = 3'b100;
                end else if (w_phase_nx == PH_YELLOW) begin
                    w_lights_nx[r] = 3'b010;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase  <= PH_ALLRED;
            r_road   <= '0;
            r_count  <= C_AR;
            r_em     <= 1'b0;
            r_ped    <= 1'b0;
            r_strobe <= 1'b0;
            r_walk   <= 1'b0;
            r_lights <= {4{3'b001}};
        end else begin
            r_phase  <= w_phase_nx;
            r_road   <= w_road_nx;
            r_count  <= w_count_nx;
            r_em     <= w_em_nx;
            r_ped    <= w_ped_nx;
            r_strobe <= w_strobe_nx;
            r_walk   <= (w_phase_nx == PH_PED);
            r_lights <= w_lights_nx;
        end
    end

    assign phase       = r_phase;
    assign green_road  = r_road;
    assign count       = r_count;
    assign em_active   = r_em;
    assign ped_pending = r_ped;
    assign road_strobe = r_strobe;
    assign walk        = r_walk;
    assign n_light     = r_lights[0];
    assign e_light     = r_lights[1];
    assign s_light     = r_lights[2];
    assign w_light     = r_lights[3];

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler: expected phase entries are queued up front,
// a negedge monitor pops one per phase/road change and checks entry values and tick durations.
module tb_intersection_phase_scheduler;

    localparam logic [1:0] AR = 2'd0, G = 2'd1, Y = 2'd2, P = 2'd3;
    localparam logic [1:0] N = 2'd0, E = 2'd1, S = 2'd2, W = 2'd3;
    localparam logic [27:0] M_ALL  = '1;
    localparam logic [27:0] M_PED  = 28'h000_0002;
    localparam logic [27:0] M_PPW  = 28'hC00_000A;

    logic       clk = 1'b0, reset = 1'b0, tick = 1'b0;
    logic [7:0] tg_n = 8'd8, tg_e = 8'd8, tg_s = 8'd8, tg_w = 8'd8;
    logic [3:0] occ = 4'b1111;
    logic       ped_req = 1'b0, em_req = 1'b0;
    logic [1:0] em_road = 2'd0;
    logic [1:0] phase, green_road;
    logic [2:0] n_light, e_light, s_light, w_light;
    logic       walk, em_active, ped_pending, road_strobe;
    logic [7:0] count;

    intersection_phase_scheduler #(
        .YELLOW_TIME(3), .ALLRED_TIME(1), .PED_TIME(10), .MIN_GREEN(5)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .tg_n(tg_n), .tg_e(tg_e), .tg_s(tg_s), .tg_w(tg_w),
        .occ(occ), .ped_req(ped_req), .em_req(em_req), .em_road(em_road),
        .phase(phase), .green_road(green_road),
        .n_light(n_light), .e_light(e_light), .s_light(s_light), .w_light(w_light),
        .walk(walk), .count(count), .em_active(em_active),
        .ped_pending(ped_pending), .road_strobe(road_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    typedef struct packed {
        logic [1:0] ph;
        logic [1:0] rd;
        logic [7:0] cnt;
        logic       em;
        logic [7:0] dur;   // ticks the phase should consume; 0 = interrupted, not checked
    } exp_t;

    typedef struct packed {
        logic        qempty;
        logic [7:0]  id;
        logic [27:0] val;
        logic [27:0] mask;
    } chk_t;

    exp_t q[$];
    chk_t dq[$];
    exp_t cur;
    chk_t dc;
    int   n_cmp = 0, n_bad = 0, ev = 0, dur_cnt = 0;
    bit   mon_on = 1'b0, have_prev = 1'b0;
    logic [1:0] prev_ph, prev_rd;

    function automatic logic [11:0] lights_of(input logic [1:0] ph, input logic [1:0] rd);
        logic [11:0] v;
        for (int r = 0; r < 4; r++) begin
            if (rd == 2'(r) && ph == G)      v[r*3 +: 3] = 3'b100;
            else if (rd == 2'(r) && ph == Y) v[r*3 +: 3] = 3'b010;
            else                             v[r*3 +: 3] = 3'b001;
        end
        return v;
    endfunction

    function automatic logic [27:0] snap(input logic [1:0] ph, input logic [1:0] rd,
                                         input logic [7:0] cnt, input logic em,
                                         input logic ped, input logic stb);
        return {ph, rd, cnt, lights_of(ph, rd), ph == P, em, ped, stb};
    endfunction

    wire [27:0] act = {phase, green_road, count, w_light, s_light, e_light, n_light,
                       walk, em_active, ped_pending, road_strobe};

    always @(negedge clk) begin
        if (!mon_on) begin
            have_prev = 1'b0;
        end else if (!have_prev || phase != prev_ph || green_road != prev_rd) begin
            if (have_prev && cur.dur != 8'd0) begin
                n_cmp++;
                if (dur_cnt != int'(cur.dur)) begin
                    n_bad++;
                    $display("FAIL dur_ev%0d: phase %0d road %0d lasted %0d ticks, want %0d",
                             ev - 1, cur.ph, cur.rd, dur_cnt, cur.dur);
                end
            end
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                cur = '0;
                $display("FAIL extra_ev%0d: got ph=%0d rd=%0d cnt=%0d, want no further phase change",
                         ev, phase, green_road, count);
            end else begin
                cur = q.pop_front();
                if ((act & ~28'h2) != (snap(cur.ph, cur.rd, cur.cnt, cur.em, 1'b0, cur.ph == G) & ~28'h2)) begin
                    n_bad++;
                    $display("FAIL entry_ev%0d: got ph=%0d rd=%0d cnt=%0d lights=%h walk=%b em=%b stb=%b, want ph=%0d rd=%0d cnt=%0d lights=%h walk=%b em=%b stb=%b",
                             ev, phase, green_road, count, act[15:4], walk, em_active, road_strobe,
                             cur.ph, cur.rd, cur.cnt, lights_of(cur.ph, cur.rd), cur.ph == P, cur.em, cur.ph == G);
                end
            end
            ev++;
            dur_cnt = (tick && !reset) ? 1 : 0;
            prev_ph = phase;
            prev_rd = green_road;
            have_prev = 1'b1;
        end else begin
            dur_cnt += (tick && !reset) ? 1 : 0;
        end
        while (dq.size() != 0) begin
            dc = dq.pop_front();
            n_cmp++;
            if (dc.qempty) begin
                if (q.size() != 0) begin
                    n_bad++;
                    $display("FAIL chk%0d_qempty: %0d expected phase entries never seen, want 0", dc.id, q.size());
                end
            end else if ((act & dc.mask) != (dc.val & dc.mask)) begin
                n_bad++;
                $display("FAIL chk%0d: got %h, want %h (mask %h)", dc.id, act & dc.mask, dc.val & dc.mask, dc.mask);
            end
        end
    end

    task automatic push(input logic [1:0] ph, input logic [1:0] rd, input logic [7:0] cnt,
                        input logic em, input logic [7:0] dur);
        q.push_back('{ph: ph, rd: rd, cnt: cnt, em: em, dur: dur});
    endtask

    task automatic chk(input logic [7:0] id, input logic [27:0] val, input logic [27:0] mask);
        dq.push_back('{qempty: 1'b0, id: id, val: val, mask: mask});
    endtask

    task automatic chk_qempty(input logic [7:0] id);
        dq.push_back('{qempty: 1'b1, id: id, val: '0, mask: '0});
    endtask

    task automatic wait_state(input logic [1:0] ph, input logic [1:0] rd, input int cnt);
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
            if (n > 3000) begin
                $display("FAIL wait_ph%0d_rd%0d: still ph=%0d rd=%0d cnt=%0d, want reached within 3000 cycles",
                         ph, rd, phase, green_road, count);
                $fatal(1, "timeout");
            end
        end while (!(phase == ph && green_road == rd && (cnt < 0 || count == 8'(cnt))));
    endtask

    task automatic pulse_ped();
        ped_req = 1'b1;
        @(posedge clk);
        #2 ped_req = 1'b0;
    endtask

    initial begin
        push(AR, N, 1, 0, 1);
        for (int r = 1; r <= 4; r++) begin
            push(G, 2'(r), 8, 0, 8);
            push(Y, 2'(r), 3, 0, 3);
            push(AR, 2'(r), 1, 0, 1);
        end
        push(P, N, 10, 0, 10);  push(AR, N, 1, 0, 1);
        push(G, E, 8, 0, 0);    push(Y, E, 3, 0, 3);  push(AR, E, 1, 0, 1);
        push(G, S, 8, 1, 0);    push(Y, S, 3, 0, 3);  push(AR, S, 1, 0, 1);
        push(G, W, 8, 0, 8);    push(Y, W, 3, 0, 3);  push(AR, W, 1, 0, 1);
        push(P, W, 10, 0, 0);   push(AR, W, 1, 0, 1);
        push(G, E, 8, 1, 0);    push(Y, E, 3, 0, 3);  push(AR, E, 1, 0, 1);
        push(P, E, 10, 0, 10);  push(AR, E, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            push(G, S, 5, 0, 5); push(Y, S, 3, 0, 3); push(AR, S, 1, 0, 1);
        end
        push(G, W, 8, 0, 8);    push(Y, W, 3, 0, 3);  push(AR, W, 1, 0, 1);
        push(G, N, 6, 0, 6);    push(Y, N, 3, 0, 0);

        #1 reset = 1'b1;
        mon_on = 1'b1;
        chk(1, snap(AR, N, 1, 0, 0, 0), M_ALL);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        wait_state(G, N, -1);
        pulse_ped();
        chk(2, snap(G, N, 0, 0, 1, 0), M_PED);

        wait_state(G, E, 6);
        em_road = S;
        em_req  = 1'b1;
        wait_state(G, S, -1);
        repeat (40) @(posedge clk);
        #2;
        chk(3, snap(G, S, 8, 1, 0, 0), M_ALL);
        em_req = 1'b0;

        wait_state(G, W, -1);
        pulse_ped();
        chk(4, snap(G, W, 0, 0, 1, 0), M_PED);
        wait_state(P, W, 7);
        em_road = E;
        em_req  = 1'b1;
        wait_state(AR, W, -1);
        chk(5, snap(AR, W, 1, 0, 1, 0), M_ALL);
        wait_state(G, E, -1);
        repeat (20) @(posedge clk);
        #2;
        chk(6, snap(G, E, 8, 1, 1, 0), M_ALL);
        em_req = 1'b0;
        occ    = 4'b0100;
        tg_s   = 8'd2;
        wait_state(P, E, -1);
        chk(7, snap(P, E, 0, 0, 0, 0), M_PPW);

        wait_state(G, S, -1);
        wait_state(Y, S, -1);
        wait_state(G, S, -1);
        wait_state(Y, S, -1);
        wait_state(G, S, -1);
        occ  = 4'b0000;
        tg_n = 8'd6;

        wait_state(G, N, -1);
        pulse_ped();
        chk(8, snap(G, N, 0, 0, 1, 0), M_PED);
        wait_state(Y, N, -1);
        repeat (2) @(posedge clk);
        #2;
        mon_on = 1'b0;
        reset  = 1'b1;
        chk(9, snap(AR, N, 1, 0, 0, 0), M_ALL);
        chk_qempty(10);

        repeat (3) @(posedge clk);
        #2;
        push(AR, N, 1, 0, 1);
        push(G, E, 8, 0, 8);
        push(Y, E, 3, 0, 0);
        mon_on = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        wait_state(Y, E, -1);
        @(negedge clk);
        #1 mon_on = 1'b0;
        chk_qempty(11);
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
